// File: rtl/pipeline_stall_controller_if.sv
// Hazard inputs and stall/bubble controls exchanged between the pipeline
// and the stall controller.
interface pipeline_stall_controller_if;
  logic        fetchDecodeValid;
  logic [4:0]  fetchDecodeRegister1;
  logic [4:0]  fetchDecodeRegister2;
  logic        fetchDecodeUsesRegister1;
  logic        fetchDecodeUsesRegister2;
  logic        decodeExecuteValid;
  logic        decodeExecuteIsLoad;
  logic [4:0]  decodeExecuteDestinationRegister;
  logic        decodeExecuteIsMulDiv;
  logic        mulDivDone;
  logic        executeRedirect;
  logic        memoryRequest;
  logic        memoryReady;
  logic        stallFetch;
  logic        stallDecode;
  logic        stallExecute;
  logic        stallMemory;
  logic        bubbleExecute;
  logic        bubbleMemory;
  logic        bubbleWriteback;
  logic        flushFetchDecode;
  logic        mulDivStart;
  logic        mulDivBusy;
  logic        mulDivTimeout;
  logic [31:0] stallCycleCount;

  modport master (
    output fetchDecodeValid, fetchDecodeRegister1, fetchDecodeRegister2,
           fetchDecodeUsesRegister1, fetchDecodeUsesRegister2,
           decodeExecuteValid, decodeExecuteIsLoad, decodeExecuteDestinationRegister,
           decodeExecuteIsMulDiv, mulDivDone, executeRedirect, memoryRequest, memoryReady,
    input  stallFetch, stallDecode, stallExecute, stallMemory,
           bubbleExecute, bubbleMemory, bubbleWriteback, flushFetchDecode,
           mulDivStart, mulDivBusy, mulDivTimeout, stallCycleCount
  );

  modport slave (
    input  fetchDecodeValid, fetchDecodeRegister1, fetchDecodeRegister2,
           fetchDecodeUsesRegister1, fetchDecodeUsesRegister2,
           decodeExecuteValid, decodeExecuteIsLoad, decodeExecuteDestinationRegister,
           decodeExecuteIsMulDiv, mulDivDone, executeRedirect, memoryRequest, memoryReady,
    output stallFetch, stallDecode, stallExecute, stallMemory,
           bubbleExecute, bubbleMemory, bubbleWriteback, flushFetchDecode,
           mulDivStart, mulDivBusy, mulDivTimeout, stallCycleCount
  );
endinterface

// File: rtl/pipeline_stall_controller.sv
// Stall/flush sequencer for the five-stage pipeline: load-use, MUL/DIV
// occupancy, data-memory wait states and Execute redirects.
module pipeline_stall_controller #(
  parameter int MULDIV_TIMEOUT = 64
) (
  input logic                       clk,
  input logic                       reset,
  pipeline_stall_controller_if.slave bus
);
  localparam int CNT_W = $clog2(MULDIV_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MULDIV_TIMEOUT - 1);

  typedef enum logic {RUN, MULDIV_WAIT} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_latched_q, done_latched_d;
  logic             timeout_q, timeout_d;
  logic [31:0]      stall_cnt_q;

  logic mem_stall, load_use, md_start, md_done, md_hold, md_expired;
  logic stl_fetch, stl_decode, stl_exec, stl_mem;
  logic bub_exec, bub_mem, bub_wb, flush_fd, start_pulse;

  assign mem_stall = bus.memoryRequest && !bus.memoryReady;
  assign load_use  = bus.fetchDecodeValid && bus.decodeExecuteValid && bus.decodeExecuteIsLoad
                  && (bus.decodeExecuteDestinationRegister != 5'd0)
                  && ((bus.fetchDecodeUsesRegister1
                       && (bus.fetchDecodeRegister1 == bus.decodeExecuteDestinationRegister))
                   || (bus.fetchDecodeUsesRegister2
                       && (bus.fetchDecodeRegister2 == bus.decodeExecuteDestinationRegister)));
  assign md_start   = (state_q == RUN) && bus.decodeExecuteValid && bus.decodeExecuteIsMulDiv
                   && !mem_stall;
  assign md_done    = bus.mulDivDone || done_latched_q;
  assign md_hold    = (state_q == MULDIV_WAIT) && !md_done;
  assign md_expired = md_hold && (cnt_q == CNT_LAST);

  always_comb begin
    stl_fetch      = 1'b0;
    stl_decode     = 1'b0;
    stl_exec       = 1'b0;
    stl_mem        = 1'b0;
    bub_exec       = 1'b0;
    bub_mem        = 1'b0;
    bub_wb         = 1'b0;
    flush_fd       = 1'b0;
    start_pulse    = 1'b0;
    state_d        = state_q;
    cnt_d          = cnt_q;
    done_latched_d = done_latched_q;
    timeout_d      = timeout_q;

    if (mem_stall) begin
      // The whole pipe freezes; a done pulse seen now must not be lost.
      stl_fetch  = 1'b1;
      stl_decode = 1'b1;
      stl_exec   = 1'b1;
      stl_mem    = 1'b1;
      bub_wb     = 1'b1;
      if ((state_q == MULDIV_WAIT) && bus.mulDivDone) done_latched_d = 1'b1;
    end else if (md_start) begin
      start_pulse = 1'b1;
      stl_fetch   = 1'b1;
      stl_decode  = 1'b1;
      stl_exec    = 1'b1;
      bub_mem     = 1'b1;
      state_d     = MULDIV_WAIT;
      cnt_d       = '0;
    end else if (md_hold && !md_expired) begin
      stl_fetch  = 1'b1;
      stl_decode = 1'b1;
      stl_exec   = 1'b1;
      bub_mem    = 1'b1;
      cnt_d      = cnt_q + CNT_W'(1);
    end else begin
      // Completion or timeout abort: Execute is released this cycle so the
      // MUL/DIV instruction leaves ID/EX instead of being restarted from RUN.
      if (state_q == MULDIV_WAIT) begin
        state_d        = RUN;
        done_latched_d = 1'b0;
        timeout_d      = timeout_q | md_expired;
      end
      if (bus.executeRedirect) begin
        flush_fd = 1'b1;
        bub_exec = 1'b1;
      end else if (load_use) begin
        stl_fetch  = 1'b1;
        stl_decode = 1'b1;
        bub_exec   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= RUN;
      cnt_q          <= '0;
      done_latched_q <= 1'b0;
      timeout_q      <= 1'b0;
      stall_cnt_q    <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      done_latched_q <= done_latched_d;
      timeout_q      <= timeout_d;
      stall_cnt_q    <= stall_cnt_q + {31'd0, stl_fetch};
    end
  end

  assign bus.stallFetch       = stl_fetch;
  assign bus.stallDecode      = stl_decode;
  assign bus.stallExecute     = stl_exec;
  assign bus.stallMemory      = stl_mem;
  assign bus.bubbleExecute    = bub_exec;
  assign bus.bubbleMemory     = bub_mem;
  assign bus.bubbleWriteback  = bub_wb;
  assign bus.flushFetchDecode = flush_fd;
  assign bus.mulDivStart      = start_pulse;
  assign bus.mulDivBusy       = (state_q == MULDIV_WAIT);
  assign bus.mulDivTimeout    = timeout_q;
  assign bus.stallCycleCount  = stall_cnt_q;
endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Bench for pipeline_stall_controller: fixed vectors, hand-written MUL/DIV
// and memory-stall sequences, and random traffic against a behavioural model.
module tb_pipeline_stall_controller;
  localparam int T = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  pipeline_stall_controller_if bus();
  pipeline_stall_controller #(.MULDIV_TIMEOUT(T)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct packed {
    logic       fdv;
    logic [4:0] r1;
    logic [4:0] r2;
    logic       u1;
    logic       u2;
    logic       dev;
    logic       ld;
    logic [4:0] rd;
    logic       md;
    logic       done;
    logic       redir;
    logic       mreq;
    logic       mrdy;
  } in_t;

  typedef struct packed {
    in_t        i;
    logic [8:0] e;
  } vec_t;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model state: MUL/DIV in flight, hold cycles spent, parked done.
  bit          m_busy, m_latched, m_to;
  int          m_waited;
  logic [31:0] m_cnt;
  bit          n_busy, n_latched, n_to;
  int          n_waited;
  logic [8:0]  exp_ctl;
  logic [8:0]  got_ctl;
  logic        got_busy;

  // Control vector order: sF sD sE sM bE bM bW flush start
  function automatic logic [8:0] ctl(input bit sf, sd, se, sm, be, bm, bw, fl, st);
    return {sf, sd, se, sm, be, bm, bw, fl, st};
  endfunction

  function automatic in_t mk(input logic fdv, input logic [4:0] r1, r2, input logic u1, u2,
                             dev, ld, input logic [4:0] rd, input logic md, done, redir,
                             mreq, mrdy);
    in_t v;
    v.fdv = fdv; v.r1 = r1; v.r2 = r2; v.u1 = u1; v.u2 = u2; v.dev = dev; v.ld = ld;
    v.rd = rd; v.md = md; v.done = done; v.redir = redir; v.mreq = mreq; v.mrdy = mrdy;
    return v;
  endfunction

  function automatic logic [8:0] dut_ctl();
    return {bus.stallFetch, bus.stallDecode, bus.stallExecute, bus.stallMemory,
            bus.bubbleExecute, bus.bubbleMemory, bus.bubbleWriteback,
            bus.flushFetchDecode, bus.mulDivStart};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input in_t v);
    bus.fetchDecodeValid                 = v.fdv;
    bus.fetchDecodeRegister1             = v.r1;
    bus.fetchDecodeRegister2             = v.r2;
    bus.fetchDecodeUsesRegister1         = v.u1;
    bus.fetchDecodeUsesRegister2         = v.u2;
    bus.decodeExecuteValid               = v.dev;
    bus.decodeExecuteIsLoad              = v.ld;
    bus.decodeExecuteDestinationRegister = v.rd;
    bus.decodeExecuteIsMulDiv            = v.md;
    bus.mulDivDone                       = v.done;
    bus.executeRedirect                  = v.redir;
    bus.memoryRequest                    = v.mreq;
    bus.memoryReady                      = v.mrdy;
  endtask

  task automatic model_eval(input in_t v);
    bit mem, lu, finished, expired;
    mem      = v.mreq && !v.mrdy;
    lu       = v.fdv && v.dev && v.ld && (v.rd != 0)
            && ((v.u1 && v.r1 == v.rd) || (v.u2 && v.r2 == v.rd));
    finished = m_busy && (v.done || m_latched);
    expired  = m_busy && !finished && (m_waited == T - 1);
    n_busy = m_busy; n_latched = m_latched; n_to = m_to; n_waited = m_waited;
    exp_ctl = '0;
    if (mem) begin
      exp_ctl = ctl(1, 1, 1, 1, 0, 0, 1, 0, 0);
      if (m_busy && v.done) n_latched = 1;
    end else if (!m_busy && v.dev && v.md) begin
      exp_ctl = ctl(1, 1, 1, 0, 0, 1, 0, 0, 1);
      n_busy = 1; n_waited = 0;
    end else if (m_busy && !finished && !expired) begin
      exp_ctl = ctl(1, 1, 1, 0, 0, 1, 0, 0, 0);
      n_waited = m_waited + 1;
    end else begin
      if (m_busy) begin
        n_busy = 0; n_latched = 0;
        if (expired) n_to = 1;
      end
      if (v.redir)   exp_ctl = ctl(0, 0, 0, 0, 1, 0, 0, 1, 0);
      else if (lu)   exp_ctl = ctl(1, 1, 0, 0, 1, 0, 0, 0, 0);
    end
  endtask

  task automatic step(input in_t v, input string tag);
    drive(v);
    #1;
    model_eval(v);
    got_ctl  = dut_ctl();
    got_busy = bus.mulDivBusy;
    chk({tag, ".ctl"},  32'(got_ctl), 32'(exp_ctl));
    chk({tag, ".busy"}, 32'(got_busy), 32'(m_busy));
    chk({tag, ".tmo"},  32'(bus.mulDivTimeout), 32'(m_to));
    chk({tag, ".cnt"},  bus.stallCycleCount, m_cnt);
    @(posedge clk);
    m_cnt    = m_cnt + 32'(exp_ctl[8]);
    m_busy   = n_busy;
    m_latched = n_latched;
    m_to     = n_to;
    m_waited = n_waited;
    @(negedge clk);
  endtask

  task automatic do_reset();
    drive('0);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    m_busy = 0; m_latched = 0; m_to = 0; m_waited = 0; m_cnt = '0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1);
  end

  initial begin
    vec_t tbl[12];
    in_t  v, mul;
    int   starts, busyc;

    tbl[0]  = '{mk(0,0,0,0,0,0,0,0,0,0,0,0,0), ctl(0,0,0,0,0,0,0,0,0)};
    tbl[1]  = '{mk(1,0,5,0,1,1,1,5,0,0,0,0,0), ctl(1,1,0,0,1,0,0,0,0)};
    tbl[2]  = '{mk(1,0,0,0,1,1,1,0,0,0,0,0,0), ctl(0,0,0,0,0,0,0,0,0)};
    tbl[3]  = '{mk(1,7,3,1,0,1,1,7,0,0,0,0,0), ctl(1,1,0,0,1,0,0,0,0)};
    tbl[4]  = '{mk(1,7,3,0,1,1,1,7,0,0,0,0,0), ctl(0,0,0,0,0,0,0,0,0)};
    tbl[5]  = '{mk(0,7,7,1,1,1,1,7,0,0,0,0,0), ctl(0,0,0,0,0,0,0,0,0)};
    tbl[6]  = '{mk(1,7,7,1,1,1,0,7,0,0,0,0,0), ctl(0,0,0,0,0,0,0,0,0)};
    tbl[7]  = '{mk(1,0,5,0,1,1,1,5,0,0,1,0,0), ctl(0,0,0,0,1,0,0,1,0)};
    tbl[8]  = '{mk(0,0,0,0,0,0,0,0,0,0,0,1,0), ctl(1,1,1,1,0,0,1,0,0)};
    tbl[9]  = '{mk(1,0,5,0,1,1,1,5,0,0,1,1,0), ctl(1,1,1,1,0,0,1,0,0)};
    tbl[10] = '{mk(1,0,5,0,1,1,1,5,0,0,0,1,1), ctl(1,1,0,0,1,0,0,0,0)};
    tbl[11] = '{mk(0,0,0,0,0,0,0,0,0,1,0,0,0), ctl(0,0,0,0,0,0,0,0,0)};

    // Reset, then idle for 10 cycles
    do_reset();
    chk("rst.busy", 32'(bus.mulDivBusy), 0);
    chk("rst.tmo",  32'(bus.mulDivTimeout), 0);
    chk("rst.cnt",  bus.stallCycleCount, 0);
    for (int k = 0; k < 10; k++) step('0, "idle");
    chk("idle.cnt", bus.stallCycleCount, 0);

    // Single-cycle vectors in RUN
    for (int k = 0; k < 12; k++) begin
      step(tbl[k].i, $sformatf("tbl%0d", k));
      chk($sformatf("tbl%0d.exp", k), 32'(got_ctl), 32'(tbl[k].e));
    end

    // MUL with done four cycles after the start
    do_reset();
    mul = '0; mul.dev = 1; mul.md = 1;
    starts = 0; busyc = 0;
    for (int k = 0; k < 6; k++) begin
      v = (k < 5) ? mul : in_t'('0);
      v.done = (k == 4);
      step(v, "mul4");
      starts += int'(got_ctl[0]);
      busyc  += int'(got_busy);
      if (k == 3) chk("mul4.held", 32'(got_ctl[8]), 1);
      if (k == 4) chk("mul4.release", 32'(got_ctl[8:6]), 0);
    end
    chk("mul4.starts", 32'(starts), 1);
    chk("mul4.busycyc", 32'(busyc), 4);
    chk("mul4.stallcnt", bus.stallCycleCount, 4);

    // Done arrives during a 3-cycle memory stall
    do_reset();
    starts = 0;
    for (int k = 0; k < 7; k++) begin
      v = (k < 6) ? mul : in_t'('0);
      v.mreq = (k >= 2 && k <= 5);
      v.mrdy = (k == 5);
      v.done = (k == 2);
      step(v, "mdmem");
      starts += int'(got_ctl[0]);
      if (k == 4) chk("mdmem.waiting", 32'(bus.mulDivBusy), 1);
      if (k == 5) chk("mdmem.exit", 32'(got_ctl[8:6]), 0);
    end
    chk("mdmem.starts", 32'(starts), 1);
    chk("mdmem.run", 32'(bus.mulDivBusy), 0);

    // Redirect deferred by a memory stall
    v = mk(1,0,5,0,1,1,1,5,0,0,1,1,0);
    step(v, "redir_ms");
    chk("redir_ms.flush", 32'(got_ctl[1]), 0);
    v.mrdy = 1;
    step(v, "redir_go");
    chk("redir_go.flush", 32'(got_ctl[1]), 1);
    chk("redir_go.sf", 32'(got_ctl[8]), 0);

    // Timeout with no done
    do_reset();
    for (int k = 0; k < 5; k++) begin
      step(mul, "tmo");
      if (k == 3) chk("tmo.pre", 32'(bus.mulDivTimeout), 0);
    end
    chk("tmo.set", 32'(bus.mulDivTimeout), 1);
    chk("tmo.run", 32'(bus.mulDivBusy), 0);
    for (int k = 0; k < 5; k++) step('0, "tmo_idle");
    v = mul;
    step(v, "tmo_mul");
    v.done = 1;
    step(v, "tmo_done");
    step('0, "tmo_after");
    chk("tmo.sticky", 32'(bus.mulDivTimeout), 1);
    do_reset();
    chk("tmo.cleared", 32'(bus.mulDivTimeout), 0);

    // Reset in the middle of MULDIV_WAIT
    step(mul, "rmw_start");
    step(mul, "rmw_hold");
    do_reset();
    chk("rmw.busy", 32'(bus.mulDivBusy), 0);
    step('0, "rmw_idle");
    chk("rmw.nostart", 32'(got_ctl[0]), 0);

    // Random traffic against the model
    do_reset();
    for (int k = 0; k < 800; k++) begin
      v.fdv   = 1'($urandom_range(0, 1));
      v.r1    = 5'($urandom_range(0, 3));
      v.r2    = 5'($urandom_range(0, 3));
      v.u1    = 1'($urandom_range(0, 1));
      v.u2    = 1'($urandom_range(0, 1));
      v.dev   = 1'($urandom_range(0, 1));
      v.ld    = 1'($urandom_range(0, 1));
      v.rd    = 5'($urandom_range(0, 3));
      v.md    = ($urandom_range(0, 3) == 0);
      v.done  = ($urandom_range(0, 4) == 0);
      v.redir = ($urandom_range(0, 5) == 0);
      v.mreq  = ($urandom_range(0, 2) == 0);
      v.mrdy  = 1'($urandom_range(0, 1));
      step(v, "rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pipeline_stall_controller.md
# pipeline_stall_controller

Central stall/flush sequencer for the five-stage CPU pipeline. It sits beside the forwarding unit and covers the hazards that forwarding cannot resolve:
- load-use dependencies,
- multi-cycle MUL/DIV occupancy of Execute,
- data-memory wait states,
- control redirects.

It drives per-stage stall and bubble controls into the pipeline registers and keeps a stall-cycle performance counter.

## Interface
- MULDIV_TIMEOUT, 64: maximum cycles spent in MULDIV_WAIT before aborting; must be ≥ 2.
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high.
- fetchDecodeValid  input  1  instruction in IF/ID is valid.
- fetchDecodeRegister1 / fetchDecodeRegister2  input  5 each  source registers of the IF/ID instruction.
- fetchDecodeUsesRegister1 / fetchDecodeUsesRegister2  input  1 each  the instruction actually reads that source.
- decodeExecuteValid  input  1  instruction in ID/EX is valid.
- decodeExecuteIsLoad  input  1  the ID/EX instruction is a load.
- decodeExecuteDestinationRegister  input  5  rd of the ID/EX instruction.
- decodeExecuteIsMulDiv  input  1  the ID/EX instruction needs the multi-cycle unit.
- mulDivDone  input  1  one-cycle pulse; the multi-cycle result is valid.
- executeRedirect  input  1  Execute resolved a taken branch, jump or trap redirect.
- memoryRequest  input  1  the EX/MEM instruction is accessing data memory.
- memoryReady  input  1  data memory completes the access this cycle.
- stallFetch, stallDecode, stallExecute, stallMemory  output  1 each  hold PC, IF/ID, ID/EX and EX/MEM respectively.
- bubbleExecute, bubbleMemory, bubbleWriteback  output  1 each  load a NOP into ID/EX, EX/MEM and MEM/WB respectively.
- flushFetchDecode  output  1  invalidate IF/ID.
- mulDivStart  output  1  one-cycle start pulse to the multi-cycle unit.
- mulDivBusy  output  1  the FSM is in MULDIV_WAIT.
- mulDivTimeout  output  1  sticky error flag; cleared only by reset.
- stallCycleCount  output  32  number of cycles with stallFetch high; wraps modulo 2^32.

## Operation
FSM states: RUN, MULDIV_WAIT. Registered state also includes a timeout counter, a doneLatched flag, mulDivTimeout and stallCycleCount.

Hazard terms (all combinational):
- **memStall** = memoryRequest && !memoryReady. Valid in any state.
- **loadUse** = fetchDecodeValid && decodeExecuteValid && decodeExecuteIsLoad && decodeExecuteDestinationRegister != 0 && ((fetchDecodeUsesRegister1 && fetchDecodeRegister1 == rd) || (fetchDecodeUsesRegister2 && fetchDecodeRegister2 == rd)).
- **mdStart** = state == RUN && decodeExecuteValid && decodeExecuteIsMulDiv && !memStall.
- **mdHold** = state == MULDIV_WAIT && !(mulDivDone || doneLatched).

Priority (oldest instruction wins): memStall > mdStart/mdHold > executeRedirect > loadUse.

Response to each term:
- **memStall:** all four stalls = 1, bubbleWriteback = 1. Every other action is suppressed, including redirect and mulDivStart.
- **mdStart:** mulDivStart = 1; stallFetch, stallDecode and stallExecute = 1; bubbleMemory = 1. Next state is MULDIV_WAIT and the counter is cleared to 0.
- **mdHold:** same stalls and bubbleMemory as mdStart, with mulDivStart = 0. The counter increments.
- **Completion:** the cycle in which mulDivDone (or doneLatched) is seen without memStall drops all stalls so the result advances. That cycle clears doneLatched; next state is RUN.
- **Done during a memory stall:** mulDivDone arriving while memStall = 1 sets doneLatched. The FSM remains in MULDIV_WAIT until memStall clears.
- **Timeout:** when the counter reaches MULDIV_TIMEOUT−1 while mdHold holds, mulDivTimeout is set and the next state is RUN. The instruction then advances with whatever result the multi-cycle unit is presenting.
- **executeRedirect:** acts only when Execute is not stalled. Drives flushFetchDecode = 1 and bubbleExecute = 1; loadUse is ignored in that cycle.
- **loadUse:** stallFetch = stallDecode = 1 and bubbleExecute = 1 for exactly one cycle. The load then sits in MEM and MEM/WB forwarding resolves the dependency.
- **Counters:** mulDivBusy = (state == MULDIV_WAIT). stallCycleCount increments in every cycle where stallFetch = 1.

## Timing
- **Reset:**
  - state = RUN; counter, doneLatched, mulDivTimeout and stallCycleCount = 0.
  - Outputs are combinational from state and inputs, so with all inputs low every output is 0.
  - Reset asserted mid-MULDIV_WAIT returns the FSM to RUN on the next edge. Reset does not issue a mulDivStart.
- **Latency:** stall, bubble and flush outputs are combinational, in the same cycle as the triggering input; there are no registered outputs apart from counters and flags.
- **MUL/DIV minimum occupancy:** 2 cycles (start cycle plus done cycle), when mulDivDone arrives in the cycle after mulDivStart.
- **mulDivDone in the start cycle:** ignored; the unit is required to take at least 1 cycle.

## Test plan
- Reset then idle inputs: all outputs are 0 and stallCycleCount stays 0 for 10 cycles.
- Load to x5 in ID/EX while IF/ID reads x5 as rs2: exactly 1 cycle with stallFetch = stallDecode = bubbleExecute = 1. Repeating the sequence with rd = x0 produces no stall.
- MUL with mulDivDone 4 cycles after start: mulDivStart pulses once; stalls held for 4 cycles and released in the done cycle; mulDivBusy high for 4 cycles; stallCycleCount = 4.
- MUL with mulDivDone asserted during a 3-cycle memStall: doneLatched is set; the FSM exits only after memoryReady; no second mulDivStart.
- executeRedirect together with loadUse: flushFetchDecode = 1, bubbleExecute = 1, stallFetch = 0. Redirect during memStall is deferred until memoryReady.
- MULDIV_TIMEOUT = 4 with no done: mulDivTimeout rises on the 4th wait cycle, FSM returns to RUN, and the flag holds until reset.
